drive_sequencer: RTL and testbench

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

---
 rtl/drive_sequencer.sv | 93 +++++++++
 tb/tb_drive_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// Drive-code sequencer for a 2-bit motor driver: forces a dead band of stop
// between direction changes, enforces a minimum dwell, and latches an e-stop halt.
module drive_sequencer #(
   parameter int DEAD_CYC  = 1000,
   parameter int MIN_DWELL = 5000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [1:0] cmd,
   output logic       cmd_ready,
   input  logic       estop,
   input  logic       resume,
   output logic [1:0] state,
   output logic       busy,
   output logic       halted
);

   typedef enum logic [1:0] {ST_STOP, ST_DEAD, ST_RUN, ST_HALT} fsm_t;

   localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYC - 1);
   localparam logic [15:0] DWELL_MAX = 16'(MIN_DWELL);

   fsm_t        fsm;
   logic [1:0]  target;
   logic [15:0] dead_cnt;
   logic [15:0] dwell_cnt;
   logic        dwell_ok;
   logic        take;

   assign dwell_ok  = dwell_cnt >= DWELL_MAX;
   assign cmd_ready = (fsm == ST_STOP) || ((fsm == ST_RUN) && dwell_ok);
   assign busy      = fsm != ST_STOP;
   assign halted    = fsm == ST_HALT;
   assign take      = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= ST_STOP;
         state     <= 2'b00;
         target    <= 2'b00;
         dead_cnt  <= '0;
         dwell_cnt <= '0;
      end else if (estop) begin
         fsm       <= ST_HALT;
         state     <= 2'b00;
         target    <= 2'b00;
         dead_cnt  <= '0;
         dwell_cnt <= '0;
      end else begin
         case (fsm)
            ST_STOP: begin
               if (take && cmd != 2'b00) begin
                  target   <= cmd;
                  dead_cnt <= DEAD_LOAD;
                  fsm      <= ST_DEAD;
               end
            end
            ST_DEAD: begin
               if (dead_cnt == '0) begin
                  fsm       <= ST_RUN;
                  state     <= target;
                  dwell_cnt <= '0;
               end else begin
                  dead_cnt <= dead_cnt - 16'd1;
               end
            end
            ST_RUN: begin
               if (!dwell_ok) dwell_cnt <= dwell_cnt + 16'd1;
               // A repeat of the current code is accepted but changes nothing.
               if (take) begin
                  if (cmd == 2'b00) begin
                     fsm       <= ST_STOP;
                     state     <= 2'b00;
                     dwell_cnt <= '0;
                  end else if (cmd != target) begin
                     fsm       <= ST_DEAD;
                     state     <= 2'b00;
                     target    <= cmd;
                     dead_cnt  <= DEAD_LOAD;
                     dwell_cnt <= '0;
                  end
               end
            end
            ST_HALT: begin
               if (resume) fsm <= ST_STOP;
            end
            default: fsm <= ST_STOP;
         endcase
      end
   end

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer: stimulus pushes hand-computed expected
// outputs per edge, a negedge monitor pops and compares them.
module tb_drive_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic       cmd_ready;
   logic       estop = 1'b0;
   logic       resume = 1'b0;
   logic [1:0] state;
   logic       busy;
   logic       halted;

   typedef struct {
      logic [4:0] val;   // {state, cmd_ready, busy, halted}
      string      nm;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic [1:0] prev_state = 2'b00;

   drive_sequencer #(.DEAD_CYC(4), .MIN_DWELL(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_ready(cmd_ready), .estop(estop), .resume(resume),
      .state(state), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if ({state, cmd_ready, busy, halted} !== e.val) begin
            errors++;
            $display("FAIL %s: got state=%b ready=%b busy=%b halted=%b, expected state=%b ready=%b busy=%b halted=%b",
                     e.nm, state, cmd_ready, busy, halted, e.val[4:3], e.val[2], e.val[1], e.val[0]);
         end
         if (state !== prev_state) begin
            checks++;
            if (prev_state != 2'b00 && state != 2'b00) begin
               errors++;
               $display("FAIL direct_switch: got %b -> %b, expected a 00 gap", prev_state, state);
            end
         end
         prev_state = state;
      end
   end

   // Apply inputs for one edge; expected outputs after that edge.
   task automatic step(input logic v, input logic [1:0] c, input logic e,
                       input logic r, input logic rn, input logic [1:0] xs,
                       input logic xr, input logic xb, input logic xh, input string nm);
      exp_t x;
      cmd_valid = v; cmd = c; estop = e; resume = r; rst_n = rn;
      @(posedge clk);
      x.val = {xs, xr, xb, xh};
      x.nm  = nm;
      q.push_back(x);
      #1;
   endtask

   task automatic idle(input logic [1:0] xs, input logic xr, input logic xb, input logic xh, input string nm);
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, xs, xr, xb, xh, nm);
   endtask

   initial begin
      // Reset state
      step(0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, "reset0");
      step(0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, "reset1");
      idle(2'b00, 1, 0, 0, "stop_idle");
      step(1, 2'b00, 0, 0, 1, 2'b00, 1, 0, 0, "stop_cmd00_noop");

      // Accept 11 at edge 0; a different code held during DEAD is ignored
      step(1, 2'b11, 0, 0, 1, 2'b00, 0, 1, 0, "accept11");
      for (int i = 0; i < 3; i++) step(1, 2'b10, 0, 0, 1, 2'b00, 0, 1, 0, "dead_11");
      idle(2'b11, 0, 1, 0, "run11_entry");
      for (int i = 1; i < 8; i++) step(1, 2'b11, 0, 0, 1, 2'b11, 0, 1, 0, "run11_dwell");
      idle(2'b11, 1, 1, 0, "run11_dwell_done");

      // Repeated accept of the current code: no glitch, dwell kept
      for (int i = 0; i < 3; i++) step(1, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, "repeat11");

      // 11 -> 01 through exactly 4 cycles of 00
      step(1, 2'b01, 0, 0, 1, 2'b00, 0, 1, 0, "accept01");
      for (int i = 0; i < 3; i++) idle(2'b00, 0, 1, 0, "dead_01");
      idle(2'b01, 0, 1, 0, "run01_entry");
      for (int i = 1; i < 8; i++) idle(2'b01, 0, 1, 0, "run01_dwell");
      idle(2'b01, 1, 1, 0, "run01_dwell_done");

      // 01 -> 10, then hold stop request through the dwell
      step(1, 2'b10, 0, 0, 1, 2'b00, 0, 1, 0, "accept10");
      for (int i = 0; i < 3; i++) idle(2'b00, 0, 1, 0, "dead_10");
      idle(2'b10, 0, 1, 0, "run10_entry");
      for (int i = 1; i < 8; i++) step(1, 2'b00, 0, 0, 1, 2'b10, 0, 1, 0, "hold00_blocked");
      step(1, 2'b00, 0, 0, 1, 2'b10, 1, 1, 0, "hold00_ready");
      step(1, 2'b00, 0, 0, 1, 2'b00, 1, 0, 0, "stop_no_dead");

      // estop mid-DEAD, resume gated by estop
      step(1, 2'b11, 0, 0, 1, 2'b00, 0, 1, 0, "accept11_b");
      idle(2'b00, 0, 1, 0, "dead_11_b");
      step(1, 2'b11, 1, 0, 1, 2'b00, 0, 1, 1, "estop_dead");
      step(1, 2'b11, 1, 1, 1, 2'b00, 0, 1, 1, "resume_under_estop");
      for (int i = 0; i < 5; i++) idle(2'b00, 0, 1, 1, "halt_hold");
      step(1, 2'b11, 0, 1, 1, 2'b00, 1, 0, 0, "resume_exit");
      // estop wins over a command accepted in STOP
      step(1, 2'b11, 1, 0, 1, 2'b00, 0, 1, 1, "estop_vs_cmd");
      step(0, 2'b00, 0, 1, 1, 2'b00, 1, 0, 0, "resume_exit2");
      idle(2'b00, 1, 0, 0, "stop_after_halt");

      // Reset mid-RUN (overriding estop), then full dead time again
      step(1, 2'b10, 0, 0, 1, 2'b00, 0, 1, 0, "accept10_b");
      for (int i = 0; i < 3; i++) idle(2'b00, 0, 1, 0, "dead_10_b");
      idle(2'b10, 0, 1, 0, "run10_b_entry");
      idle(2'b10, 0, 1, 0, "run10_b");
      step(1, 2'b01, 1, 0, 0, 2'b00, 1, 0, 0, "reset_mid_run");
      step(1, 2'b10, 0, 0, 1, 2'b00, 0, 1, 0, "accept10_c");
      for (int i = 0; i < 3; i++) idle(2'b00, 0, 1, 0, "dead_10_c");
      idle(2'b10, 0, 1, 0, "run10_c_entry");

      // Reset mid-DEAD leaves no residual count
      step(0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, "reset_stop");
      step(1, 2'b11, 0, 0, 1, 2'b00, 0, 1, 0, "accept11_d");
      idle(2'b00, 0, 1, 0, "dead_11_d");
      step(0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, "reset_mid_dead");
      step(1, 2'b11, 0, 0, 1, 2'b00, 0, 1, 0, "accept11_e");
      for (int i = 0; i < 3; i++) idle(2'b00, 0, 1, 0, "dead_11_e");
      idle(2'b11, 0, 1, 0, "run11_e_entry");

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
